ram_port_arbiter: RTL and testbench

- Two-requester round-robin arbiter for the 64 x 32-bit single-port block RAM (RAM_B: registered read output, one-cycle read latency).
- Accepts read/write commands from two independent requesters and serialises them onto the single RAM port.
- Returns read data with a per-requester valid pulse.
- Sits between the RAM instance and front-end logic, such as the switch/LED test harness and a future CPU load/store unit.

---
 rtl/ram_port_arbiter.sv | 100 ++++++++++
 tb/tb_ram_port_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter serialising read/write commands onto a
// single-port block RAM with registered (one-cycle latency) read output.
module ram_port_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              Wr0,
  input  logic              Wr1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              RValid0,
  output logic              RValid1,
  output logic [DATA_W-1:0] RData,
  output logic              Busy,
  output logic              Ram_We,
  output logic [ADDR_W-1:0] Ram_Addr,
  output logic [DATA_W-1:0] Ram_Din,
  input  logic [DATA_W-1:0] Ram_Dout
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RWAIT
  } state_t;

  state_t state;
  logic   last;
  logic   owner;
  logic   cmd_wr;
  logic   pick1;

  // On a tie, requester 1 wins only when requester 0 was granted last.
  always_comb begin
    pick1 = Req1 && (!Req0 || !last);
  end

  always_comb begin
    Busy = (state != IDLE);
  end

  // Ram_Addr/Ram_Din double as the latched command registers; they are only
  // reloaded on a grant, so they hold their value outside ISSUE.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      cmd_wr   <= 1'b0;
      Gnt0     <= 1'b0;
      Gnt1     <= 1'b0;
      RValid0  <= 1'b0;
      RValid1  <= 1'b0;
      RData    <= '0;
      Ram_We   <= 1'b0;
      Ram_Addr <= '0;
      Ram_Din  <= '0;
    end else begin
      Gnt0    <= 1'b0;
      Gnt1    <= 1'b0;
      RValid0 <= 1'b0;
      RValid1 <= 1'b0;
      Ram_We  <= 1'b0;
      case (state)
        IDLE: begin
          if (Req0 || Req1) begin
            owner    <= pick1;
            last     <= pick1;
            cmd_wr   <= pick1 ? Wr1 : Wr0;
            Ram_We   <= pick1 ? Wr1 : Wr0;
            Ram_Addr <= pick1 ? Addr1 : Addr0;
            Ram_Din  <= pick1 ? WData1 : WData0;
            Gnt0     <= !pick1;
            Gnt1     <= pick1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          state <= cmd_wr ? IDLE : RWAIT;
        end
        RWAIT: begin
          RData   <= Ram_Dout;
          RValid0 <= !owner;
          RValid1 <= owner;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter with a behavioural
// 64 x 32 registered-output RAM attached to its port.
module tb_ram_port_arbiter;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Req0, Req1, Wr0, Wr1;
  logic [5:0]  Addr0, Addr1;
  logic [31:0] WData0, WData1;
  logic        Gnt0, Gnt1, RValid0, RValid1;
  logic [31:0] RData;
  logic        Busy, Ram_We;
  logic [5:0]  Ram_Addr;
  logic [31:0] Ram_Din;
  logic [31:0] Ram_Dout;

  logic [31:0] mem [64];

  int n_checks = 0;
  int n_pass   = 0;

  ram_port_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .RValid0(RValid0), .RValid1(RValid1),
    .RData(RData), .Busy(Busy), .Ram_We(Ram_We), .Ram_Addr(Ram_Addr),
    .Ram_Din(Ram_Din), .Ram_Dout(Ram_Dout)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Ram_We) mem[Ram_Addr] <= Ram_Din;
    Ram_Dout <= mem[Ram_Addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge Clk);
  endtask

  task automatic drive(input int idx, input logic req, input logic wr,
                       input logic [5:0] addr, input logic [31:0] data);
    if (idx == 0) begin
      Req0 = req; Wr0 = wr; Addr0 = addr; WData0 = data;
    end else begin
      Req1 = req; Wr1 = wr; Addr1 = addr; WData1 = data;
    end
  endtask

  // Entered in an IDLE cycle (cycle 0); returns in cycle 2 (IDLE again).
  task automatic do_write(input int idx, input logic [5:0] addr, input logic [31:0] data);
    drive(idx, 1'b1, 1'b1, addr, data);
    step();
    check("wr_gnt0", {31'b0, Gnt0}, {31'b0, idx == 0});
    check("wr_gnt1", {31'b0, Gnt1}, {31'b0, idx == 1});
    check("wr_we", {31'b0, Ram_We}, 32'd1);
    check("wr_addr", {26'b0, Ram_Addr}, {26'b0, addr});
    check("wr_din", Ram_Din, data);
    drive(idx, 1'b0, 1'b0, 6'd0, 32'd0);
    step();
    check("wr_we_off", {31'b0, Ram_We}, 32'd0);
    check("wr_idle", {31'b0, Busy}, 32'd0);
  endtask

  // Entered in an IDLE cycle (cycle 0); returns in cycle 3 with RValid sampled.
  task automatic do_read(input int idx, input logic [5:0] addr, input logic [31:0] exp);
    drive(idx, 1'b1, 1'b0, addr, 32'd0);
    step();
    check("rd_gnt0", {31'b0, Gnt0}, {31'b0, idx == 0});
    check("rd_gnt1", {31'b0, Gnt1}, {31'b0, idx == 1});
    check("rd_we", {31'b0, Ram_We}, 32'd0);
    drive(idx, 1'b0, 1'b0, 6'd0, 32'd0);
    step();
    check("rd_busy", {31'b0, Busy}, 32'd1);
    check("rd_early_rv", {30'b0, RValid1, RValid0}, 32'd0);
    step();
    check("rd_rv0", {31'b0, RValid0}, {31'b0, idx == 0});
    check("rd_rv1", {31'b0, RValid1}, {31'b0, idx == 1});
    check("rd_data", RData, exp);
  endtask

  initial begin
    Rst = 1'b1;
    Req0 = 1'b1; Req1 = 1'b1; Wr0 = 1'b0; Wr1 = 1'b0;
    Addr0 = '0; Addr1 = '0; WData0 = '0; WData1 = '0;

    // Reset held two cycles with both requesters asking
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_gnt", {30'b0, Gnt1, Gnt0}, 32'd0);
      check("rst_rv", {30'b0, RValid1, RValid0}, 32'd0);
      check("rst_we", {31'b0, Ram_We}, 32'd0);
      check("rst_busy", {31'b0, Busy}, 32'd0);
      check("rst_addr", {26'b0, Ram_Addr}, 32'd0);
      check("rst_din", Ram_Din, 32'd0);
      check("rst_rdata", RData, 32'd0);
    end
    Rst = 1'b0;
    step();
    check("first_gnt0", {31'b0, Gnt0}, 32'd1);
    check("first_gnt1", {31'b0, Gnt1}, 32'd0);
    Req0 = 1'b0; Req1 = 1'b0;
    step();
    step();
    check("first_rv0", {31'b0, RValid0}, 32'd1);

    // Single write then read, requester 0
    do_write(0, 6'h05, 32'h1111_2222);
    do_read(0, 6'h05, 32'h1111_2222);

    // Preload for the round-robin run
    do_write(0, 6'd10, 32'ha0a0_0010);
    do_write(1, 6'd20, 32'hb1b1_0020);

    // Round-robin tie: grants at cycles 1,4,7,10, RValid at 3,6,9,12
    drive(0, 1'b1, 1'b0, 6'd10, 32'd0);
    drive(1, 1'b1, 1'b0, 6'd20, 32'd0);
    for (int c = 1; c <= 12; c++) begin
      logic e_g0, e_g1, e_r0, e_r1;
      step();
      e_g0 = (c % 3 == 1) && ((c / 3) % 2 == 0);
      e_g1 = (c % 3 == 1) && ((c / 3) % 2 == 1);
      e_r0 = (c % 3 == 0) && ((c / 3) % 2 == 1);
      e_r1 = (c % 3 == 0) && ((c / 3) % 2 == 0);
      check("rr_gnt", {30'b0, Gnt1, Gnt0}, {30'b0, e_g1, e_g0});
      check("rr_rv", {30'b0, RValid1, RValid0}, {30'b0, e_r1, e_r0});
      if (e_r0) check("rr_data0", RData, 32'ha0a0_0010);
      if (e_r1) check("rr_data1", RData, 32'hb1b1_0020);
    end
    drive(0, 1'b0, 1'b0, 6'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 6'd0, 32'd0);

    // Make requester 0 the last granted so requester 1 wins the next tie
    do_read(0, 6'd10, 32'ha0a0_0010);

    // Cross-requester coherence on address 3F
    drive(0, 1'b1, 1'b0, 6'h3F, 32'd0);
    drive(1, 1'b1, 1'b1, 6'h3F, 32'haaaa_ffff);
    step();
    check("coh_gnt", {30'b0, Gnt1, Gnt0}, 32'd2);
    check("coh_we", {31'b0, Ram_We}, 32'd1);
    drive(1, 1'b0, 1'b0, 6'd0, 32'd0);
    step();
    check("coh_idle_gnt", {30'b0, Gnt1, Gnt0}, 32'd0);
    step();
    check("coh_gnt0", {30'b0, Gnt1, Gnt0}, 32'd1);
    drive(0, 1'b0, 1'b0, 6'd0, 32'd0);
    step();
    step();
    check("coh_rv", {30'b0, RValid1, RValid0}, 32'd1);
    check("coh_data", RData, 32'haaaa_ffff);

    // Reset during RWAIT aborts the read
    drive(0, 1'b1, 1'b0, 6'h05, 32'd0);
    step();
    check("mr_gnt0", {31'b0, Gnt0}, 32'd1);
    drive(0, 1'b0, 1'b0, 6'd0, 32'd0);
    step();
    check("mr_rwait", {31'b0, Busy}, 32'd1);
    Rst = 1'b1;
    step();
    check("mr_rv", {30'b0, RValid1, RValid0}, 32'd0);
    check("mr_busy", {31'b0, Busy}, 32'd0);
    check("mr_rdata", RData, 32'd0);
    Rst = 1'b0;
    do_read(0, 6'h05, 32'h1111_2222);

    // Back-to-back writes from requester 1 with Req held high
    drive(1, 1'b1, 1'b1, 6'd0, 32'h3333_6666);
    for (int n = 0; n < 4; n++) begin
      step();
      check("b2b_gnt1", {30'b0, Gnt1, Gnt0}, 32'd2);
      check("b2b_we", {31'b0, Ram_We}, 32'd1);
      check("b2b_addr", {26'b0, Ram_Addr}, n);
      check("b2b_din", Ram_Din, 32'h3333_6666 + n);
      if (n == 3) drive(1, 1'b0, 1'b0, 6'd0, 32'd0);
      else drive(1, 1'b1, 1'b1, 6'(n + 1), 32'h3333_6666 + n + 1);
      step();
      check("b2b_gap", {30'b0, Gnt1, Gnt0}, 32'd0);
      check("b2b_we_off", {31'b0, Ram_We}, 32'd0);
    end
    for (int n = 0; n < 4; n++) begin
      do_read(1, 6'(n), 32'h3333_6666 + n);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
